fpga_tx_scheduler: RTL

Round-robin scheduler that shares one FPGA-to-FPGA serial transmitter between NUM_REQ byte producers. It captures the winning requester's byte and drives the transmitter's parallel data and start. It then waits for the transmitter's finish indication and returns a per-requester done, or an error if the link stalls. It sits between local producers and the transmitter and owns all sequencing of it.

---
 rtl/fpga_link_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/fpga_tx_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fpga_link_pkg.sv
// Shared types and constants for the FPGA-to-FPGA serial link blocks.
package fpga_link_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1023;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] winner_o,
  output logic            valid_o
);

  int idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpga_tx_scheduler.sv
// Round-robin owner of the shared serial transmitter: capture, start, await finish or timeout.
// Optional FPGA_TX_STATS_EN adds sent_count / timeout_count outputs.
module fpga_tx_scheduler
  import fpga_link_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [ID_W-1:0]           err_id,
  output logic                      busy,
  output logic [ID_W-1:0]           cur_id,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_finish
`ifdef FPGA_TX_STATS_EN
  ,
  output logic [15:0]               sent_count,
  output logic [15:0]               timeout_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q, cur_id_q, err_id_q;
  logic [NUM_REQ-1:0]  grant_q, done_q;
  logic                err_q, busy_q, tx_start_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [ID_W-1:0]     arb_winner;
  logic                arb_valid;
  logic [ID_W-1:0]     next_ptr;
  logic [BYTE_W-1:0]   req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  assign next_ptr = (cur_id_q == ID_W'(NUM_REQ-1)) ? '0 : cur_id_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cur_id_q   <= '0;
      err_id_q   <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (arb_valid) begin
          state_q    <= SEND;
          busy_q     <= 1'b1;
          grant_q    <= NUM_REQ'(1) << arb_winner;
          cur_id_q   <= arb_winner;
          tx_data_q  <= req_bytes[arb_winner];
          tx_start_q <= 1'b1;
          cnt_q      <= '0;
        end
        SEND: begin
          // finish has priority over a timeout landing on the same cycle
          if (tx_finish) begin
            done_q     <= NUM_REQ'(1) << cur_id_q;
            tx_start_q <= 1'b0;
            ptr_q      <= next_ptr;
            state_q    <= RELEASE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
            err_q      <= 1'b1;
            err_id_q   <= cur_id_q;
            tx_start_q <= 1'b0;
            ptr_q      <= next_ptr;
            state_q    <= RELEASE;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: if (!tx_finish) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_id   = err_id_q;
  assign busy     = busy_q;
  assign cur_id   = cur_id_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

`ifdef FPGA_TX_STATS_EN
  logic [15:0] sent_q, tout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q <= '0;
      tout_q <= '0;
    end else begin
      if (|done_q) sent_q <= sent_q + 16'd1;
      if (err_q)   tout_q <= tout_q + 16'd1;
    end
  end

  assign sent_count    = sent_q;
  assign timeout_count = tout_q;
`endif

endmodule
